pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the fetch/decode/execute/writeback core. It sits beside the decode stage, which has no forwarding paths, and enforces correct ordering. It issues per-stage advance enables, inserts bubbles into the ID/EX register on read-after-write hazards, and freezes the front end while execute runs multi-cycle multiply/divide. It also flushes on taken branches and keeps a saturating stall-cycle counter.

---
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: RAW interlock for a forwarding-less decode stage,
// a multi-cycle MUL/DIV freeze, branch flush, and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 8,
    parameter logic [15:0] OP_MUL     = 16'h0003,
    parameter logic [15:0] OP_DIV     = 16'h0004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [15:0] id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [4:0]  id_rd,
    input  logic        id_we,
    input  logic        branch_taken,
    output logic        if_en,
    output logic        id_en,
    output logic        id_ex_bubble,
    output logic        ex_en,
    output logic        if_id_flush,
    output logic        ex_busy,
    output logic [15:0] stall_cnt
);

    localparam int unsigned MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
    localparam logic MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic DIV_MULTI = (DIV_CYCLES > 1);

    typedef enum logic {RUN, MULTI} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_ex_rd;
    logic             r_ex_we;
    logic [4:0]       r_wb_rd;
    logic             r_wb_we;
    logic [15:0]      r_stall_cnt;

    logic w_rs_match;
    logic w_rt_match;
    logic w_hazard;
    logic w_issue;
    logic w_go_mul;
    logic w_go_div;

    // Register 0 is hardwired, so it never carries a dependency.
    always_comb begin
        w_rs_match = (id_rs != 5'd0) &&
                     ((r_ex_we && id_rs == r_ex_rd) || (r_wb_we && id_rs == r_wb_rd));
        w_rt_match = (id_rt != 5'd0) &&
                     ((r_ex_we && id_rt == r_ex_rd) || (r_wb_we && id_rt == r_wb_rd));
        w_hazard   = id_valid && ((id_rs_used && w_rs_match) || (id_rt_used && w_rt_match));
    end

    always_comb begin
        if_en        = 1'b1;
        id_en        = 1'b1;
        id_ex_bubble = 1'b0;
        ex_en        = 1'b1;
        if_id_flush  = 1'b0;
        ex_busy      = 1'b0;
        if (r_state == MULTI) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            ex_en   = 1'b0;
            ex_busy = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_hazard) begin
            if_en        = 1'b0;
            id_en        = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign w_issue  = id_en && !id_ex_bubble && id_valid;
    assign w_go_mul = w_issue && (id_opcode == OP_MUL) && MUL_MULTI;
    assign w_go_div = w_issue && (id_opcode == OP_DIV) && DIV_MULTI;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_go_mul) begin
                        r_state <= MULTI;
                        r_cnt   <= MUL_LOAD;
                    end else if (w_go_div) begin
                        r_state <= MULTI;
                        r_cnt   <= DIV_LOAD;
                    end
                end
                MULTI: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else             r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ex_rd <= '0;
            r_ex_we <= 1'b0;
            r_wb_rd <= '0;
            r_wb_we <= 1'b0;
        end else if (ex_en) begin
            r_wb_rd <= r_ex_rd;
            r_wb_we <= r_ex_we;
            r_ex_rd <= w_issue ? id_rd : 5'd0;
            r_ex_we <= w_issue && id_we;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                r_stall_cnt <= '0;
        else if (!if_en && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [15:0] id_opcode = '0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_rs_used = 1'b0;
    logic        id_rt_used = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_we = 1'b0;
    logic        branch_taken = 1'b0;
    logic        if_en;
    logic        id_en;
    logic        id_ex_bubble;
    logic        ex_en;
    logic        if_id_flush;
    logic        ex_busy;
    logic [15:0] stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [15:0] OPM = 16'h0003;
    localparam logic [15:0] OPD = 16'h0004;

    pipe_ctrl #(
        .MUL_CYCLES(3),
        .DIV_CYCLES(8),
        .OP_MUL(OPM),
        .OP_DIV(OPD)
    ) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_we(id_we),
        .branch_taken(branch_taken),
        .if_en(if_en), .id_en(id_en), .id_ex_bubble(id_ex_bubble),
        .ex_en(ex_en), .if_id_flush(if_id_flush), .ex_busy(ex_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Control vector packed as {if_en,id_en,id_ex_bubble,ex_en,if_id_flush,ex_busy}.
    function automatic logic [31:0] ctl();
        return {26'd0, if_en, id_en, id_ex_bubble, ex_en, if_id_flush, ex_busy};
    endfunction

    localparam logic [31:0] C_RUN    = 32'b110100;
    localparam logic [31:0] C_HAZ    = 32'b001100;
    localparam logic [31:0] C_FLUSH  = 32'b111110;
    localparam logic [31:0] C_MULTI  = 32'b000001;

    task automatic drive(input logic v, input logic [15:0] op, input logic [4:0] rs,
                         input logic rsu, input logic [4:0] rt, input logic rtu,
                         input logic [4:0] rd, input logic we, input logic br);
        id_valid = v; id_opcode = op; id_rs = rs; id_rs_used = rsu;
        id_rt = rt; id_rt_used = rtu; id_rd = rd; id_we = we; branch_taken = br;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #3;
        check("reset_ctl", ctl(), C_RUN);
        check("reset_stall", {16'd0, stall_cnt}, 32'd0);
        #9 reset = 1'b1;
        tick();

        // RAW: producer rd=5, consumer reads rs=5 -> two bubbles then issue
        drive(1'b1, 16'h1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        check("raw_prod", ctl(), C_RUN);
        tick();
        drive(1'b1, 16'h1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0);
        check("raw_b1", ctl(), C_HAZ);
        tick(); #2;
        check("raw_b2", ctl(), C_HAZ);
        tick(); #2;
        check("raw_issue", ctl(), C_RUN);
        check("raw_stall", {16'd0, stall_cnt}, 32'd2);
        tick();

        // r0 destination never hazards
        drive(1'b1, 16'h1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        check("r0_nostall", ctl(), C_RUN);
        tick();
        // rt matches but is not read
        drive(1'b1, 16'h1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h1, 5'd0, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        check("rt_unused", ctl(), C_RUN);
        tick();
        // same rt read from WB position does stall (1 bubble)
        drive(1'b1, 16'h1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        check("rt_wb_haz", ctl(), C_HAZ);
        tick(); #2;
        check("rt_wb_issue", ctl(), C_RUN);
        check("rt_wb_stall", {16'd0, stall_cnt}, 32'd3);
        tick();
        idle(); tick(); tick();

        // Multiply: 2 frozen cycles
        drive(1'b1, OPM, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("mul_issue", ctl(), C_RUN);
        tick();
        idle();
        check("mul_f1", ctl(), C_MULTI);
        tick(); #2;
        check("mul_f2", ctl(), C_MULTI);
        tick(); #2;
        check("mul_done", ctl(), C_RUN);
        check("mul_stall", {16'd0, stall_cnt}, 32'd5);

        // Divide: 7 frozen cycles, branch ignored while frozen
        drive(1'b1, OPD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 16'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, (i == 3));
            check($sformatf("div_f%0d", i), ctl(), C_MULTI);
            tick();
        end
        idle();
        check("div_done", ctl(), C_RUN);
        check("div_stall", {16'd0, stall_cnt}, 32'd12);
        tick();

        // Branch beats a pending hazard; flush lasts one cycle
        drive(1'b1, 16'h1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        check("br_haz", ctl(), C_FLUSH);
        tick();
        drive(1'b1, 16'h1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("br_after", ctl(), C_HAZ);
        tick(); #2;
        check("br_issue", ctl(), C_RUN);
        check("br_stall", {16'd0, stall_cnt}, 32'd13);
        tick();

        // Branch together with MUL: flush wins, no MULTI
        drive(1'b1, OPM, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        check("brmul_flush", ctl(), C_FLUSH);
        tick();
        idle();
        check("brmul_nomulti", ctl(), C_RUN);
        tick();

        // Async reset in the middle of a divide (cnt=4)
        drive(1'b1, OPD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        idle(); tick(); tick(); #2;
        check("pre_rst_busy", ctl(), C_MULTI);
        reset = 1'b0;
        #1;
        check("rst_mid_ctl", ctl(), C_RUN);
        check("rst_mid_stall", {16'd0, stall_cnt}, 32'd0);
        #1 reset = 1'b1;
        drive(1'b1, 16'h1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        check("rst_no_haz", ctl(), C_RUN);
        tick();

        // Saturation: back-to-back divides give 7 stalls per 8 cycles
        drive(1'b1, OPD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (9400 * 8) tick();
        #2;
        check("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
        repeat (16) tick();
        #2;
        check("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
